// File: rtl/square_color_animator.sv
`default_nettype none
// square_color_animator: registered square-state to RGB palette stage with
// frame-synchronous blink (weak) and LFSR rainbow (invincible) animation.
module square_color_animator #(
  parameter int          STATE_W        = 2,
  parameter int          RGB_W          = 12,
  parameter int          BLINK_FRAMES   = 8,
  parameter int          RAINBOW_FRAMES = 4,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               FRAME_TICK,
  input  logic               PAUSE,
  input  logic               PIXEL_VALID,
  input  logic [STATE_W-1:0] COLOR,
  output logic [RGB_W-1:0]   RGB,
  output logic               RGB_VALID
);

  localparam logic [STATE_W-1:0] SQUARE_STRONG     = STATE_W'(0);
  localparam logic [STATE_W-1:0] SQUARE_OKAY       = STATE_W'(1);
  localparam logic [STATE_W-1:0] SQUARE_WEAK       = STATE_W'(2);
  localparam logic [STATE_W-1:0] SQUARE_INVINCIBLE = STATE_W'(3);

  localparam logic [RGB_W-1:0] BLACK_RGB      = RGB_W'(12'h000);
  localparam logic [RGB_W-1:0] DARK_GREY_RGB  = RGB_W'(12'h444);
  localparam logic [RGB_W-1:0] LIGHT_GREY_RGB = RGB_W'(12'hAAA);
  localparam logic [RGB_W-1:0] WHITE_RGB      = RGB_W'(12'hFFF);

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int RW = (RAINBOW_FRAMES > 1) ? $clog2(RAINBOW_FRAMES) : 1;
  localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_FRAMES - 1);
  localparam logic [RW-1:0] RCNT_MAX = RW'(RAINBOW_FRAMES - 1);

  logic [BW-1:0]    bcnt;
  logic [RW-1:0]    rcnt;
  logic             blink_phase;
  logic [15:0]      lfsr;
  logic             tick;
  logic [15:0]      lfsr_next;
  logic [RGB_W-1:0] palette;

  // A tick arriving while paused is simply lost, never deferred.
  assign tick      = FRAME_TICK & ~PAUSE;
  assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bcnt        <= '0;
      blink_phase <= 1'b0;
      rcnt        <= '0;
      lfsr        <= LFSR_SEED;
    end else if (tick) begin
      if (bcnt == BCNT_MAX) begin
        bcnt        <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
      if (rcnt == RCNT_MAX) begin
        rcnt <= '0;
        lfsr <= lfsr_next;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
    end
  end

  always_comb begin
    palette = BLACK_RGB;
    case (COLOR)
      SQUARE_STRONG:     palette = BLACK_RGB;
      SQUARE_OKAY:       palette = DARK_GREY_RGB;
      SQUARE_WEAK:       palette = blink_phase ? WHITE_RGB : LIGHT_GREY_RGB;
      SQUARE_INVINCIBLE: palette = RGB_W'(lfsr[11:0]);
      default:           palette = BLACK_RGB;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RGB       <= '0;
      RGB_VALID <= 1'b0;
    end else begin
      RGB       <= PIXEL_VALID ? palette : '0;
      RGB_VALID <= PIXEL_VALID;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_square_color_animator.sv
`default_nettype none
// Bench for square_color_animator: directed steps plus random traffic
// checked against a frame-count based reference model.
module tb_square_color_animator;

  localparam int          BLINK   = 8;
  localparam int          RAINBOW = 4;
  localparam logic [15:0] SEED    = 16'hACE1;

  localparam logic [1:0] STRONG = 2'd0, OKAY = 2'd1, WEAK = 2'd2, INVINC = 2'd3;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        FRAME_TICK = 1'b0;
  logic        PAUSE = 1'b0;
  logic        PIXEL_VALID = 1'b0;
  logic [1:0]  COLOR = 2'd0;
  logic [11:0] RGB;
  logic        RGB_VALID;

  int vectors = 0;
  int miscompares = 0;
  int frames = 0;   // accepted (un-paused) ticks since reset

  square_color_animator #(
    .STATE_W(2), .RGB_W(12), .BLINK_FRAMES(BLINK),
    .RAINBOW_FRAMES(RAINBOW), .LFSR_SEED(SEED)
  ) dut (
    .CLK(CLK), .RST(RST), .FRAME_TICK(FRAME_TICK), .PAUSE(PAUSE),
    .PIXEL_VALID(PIXEL_VALID), .COLOR(COLOR), .RGB(RGB), .RGB_VALID(RGB_VALID)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] lfsr_after(int steps);
    logic [15:0] l = SEED;
    for (int i = 0; i < steps; i++)
      l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    return l;
  endfunction

  function automatic logic [11:0] expect_rgb(logic pv, logic [1:0] col, int nframes);
    logic [15:0] l;
    if (!pv) return 12'h000;
    case (col)
      STRONG: return 12'h000;
      OKAY:   return 12'h444;
      WEAK:   return (((nframes / BLINK) % 2) == 1) ? 12'hFFF : 12'hAAA;
      default: begin
        l = lfsr_after(nframes / RAINBOW);
        return l[11:0];
      end
    endcase
  endfunction

  task automatic check(string tag, logic [11:0] exp_rgb, logic exp_valid);
    vectors++;
    assert (RGB === exp_rgb && RGB_VALID === exp_valid) else begin
      miscompares++;
      $error("FAIL %s: observed rgb=%h valid=%b expected rgb=%h valid=%b",
             tag, RGB, RGB_VALID, exp_rgb, exp_valid);
    end
  endtask

  // Called just after a rising edge: apply inputs, clock once, check result.
  task automatic cycle(string tag, logic pv, logic [1:0] col, logic tk, logic ps);
    logic [11:0] e;
    PIXEL_VALID = pv; COLOR = col; FRAME_TICK = tk; PAUSE = ps;
    e = expect_rgb(pv, col, frames);
    @(posedge CLK); #1;
    if (tk && !ps) frames++;
    check(tag, e, pv);
  endtask

  initial begin
    RST = 1'b1;
    @(posedge CLK); #1;
    check("reset", 12'h000, 1'b0);
    RST = 1'b0;
    frames = 0;

    cycle("pal_strong", 1, STRONG, 0, 0);
    cycle("pal_okay",   1, OKAY,   0, 0);
    cycle("pal_weak",   1, WEAK,   0, 0);
    cycle("pal_invinc", 1, INVINC, 0, 0);
    check("pal_invinc_ce1", 12'hCE1, 1'b1);
    cycle("blank", 0, INVINC, 0, 0);

    // Three ticks: colour unchanged; fourth tick steps the LFSR.
    for (int i = 0; i < 3; i++) cycle("rainbow_pre", 1, INVINC, 1, 0);
    check("rainbow_still_ce1", 12'hCE1, 1'b1);
    cycle("rainbow_tick4", 1, INVINC, 1, 0);
    check("rainbow_old_in_tick", 12'hCE1, 1'b1);
    cycle("rainbow_step", 1, INVINC, 0, 0);
    check("rainbow_270", 12'h270, 1'b1);

    // Continue to 8 ticks: weak flips to white, then back at 16.
    for (int i = 0; i < 3; i++) cycle("blink_pre", 1, WEAK, 1, 0);
    check("blink_7_light", 12'hAAA, 1'b1);
    cycle("blink_tick8", 1, WEAK, 1, 0);
    cycle("blink_white", 1, WEAK, 0, 0);
    check("blink_fff", 12'hFFF, 1'b1);
    for (int i = 0; i < 8; i++) cycle("blink_back", 1, WEAK, 1, 1'b0);
    cycle("blink_16", 1, WEAK, 0, 0);
    check("blink_16_light", 12'hAAA, 1'b1);

    // Pause, including a tick in the same cycle pause rises.
    for (int i = 0; i < 10; i++) cycle("pause_weak", 1, (i % 2) ? INVINC : WEAK, 1, 1);
    cycle("pause_inv", 1, INVINC, 0, 0);
    cycle("pause_wk", 1, WEAK, 0, 0);
    for (int i = 0; i < 9; i++) cycle("resume", 1, (i % 2) ? INVINC : WEAK, 1, 0);

    for (int i = 0; i < 300; i++)
      cycle("random", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 4) == 0));

    // Bring animation to blink_phase=1 with the LFSR stepped, then reset mid-cycle.
    for (int i = 0; i < 40 && !(((frames / BLINK) % 2) == 1 && frames >= RAINBOW); i++)
      cycle("pre_reset", 1, WEAK, 1, 0);
    cycle("pre_reset_px", 1, WEAK, 0, 0);
    check("pre_reset_white", 12'hFFF, 1'b1);
    #2 RST = 1'b1;
    #1 check("async_reset", 12'h000, 1'b0);
    @(posedge CLK); #1;
    RST = 1'b0;
    frames = 0;
    cycle("post_reset_inv", 1, INVINC, 0, 0);
    check("post_reset_ce1", 12'hCE1, 1'b1);
    cycle("post_reset_weak", 1, WEAK, 0, 0);
    check("post_reset_aaa", 12'hAAA, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/square_color_animator.md
# square_color_animator

Parametrised, registered square-colour stage for the VGA output path. It maps each square state code to a 12-bit RGB value and adds frame-synchronous animation. Weak squares blink between two greys. Invincible squares cycle through pseudo-random colours from an internal LFSR, so no external random source is needed. It sits between the square-state lookup and the VGA pixel mux and adds one cycle of latency, matched by a valid flag.

## Interface
- STATE_W, 2, width of square state code (must hold all `SQUARE_*` header codes)
- RGB_W, 12, output colour width
- BLINK_FRAMES, 8, frames per blink half-period for weak squares (>=1)
- RAINBOW_FRAMES, 4, frames between LFSR steps for invincible squares (>=1)
- LFSR_SEED, 16'hACE1, reset value of the 16-bit LFSR (must be non-zero)

- CLK  in  1  pixel clock
- RST  in  1  reset; asynchronous, active-high
- FRAME_TICK  in  1  one-cycle pulse per frame (start of vertical blank)
- PAUSE  in  1  freezes all animation state while high
- PIXEL_VALID  in  1  COLOR is valid this cycle (active video)
- COLOR  in  STATE_W  square state code
- RGB  out  RGB_W  registered pixel colour
- RGB_VALID  out  1  RGB corresponds to a pixel presented one cycle earlier

## Operation
- Palette:
  - `SQUARE_STRONG` → `BLACK_RGB`
  - `SQUARE_OKAY` → `DARK_GREY_RGB`
  - `SQUARE_WEAK` → `LIGHT_GREY_RGB` when blink_phase=0, 12'hFFF when blink_phase=1
  - `SQUARE_INVINCIBLE` → lfsr[11:0]
  - any other code → `BLACK_RGB`
- Output register:
  - PIXEL_VALID=1: RGB ← palette(COLOR).
  - PIXEL_VALID=0: RGB ← 0 (blanking).
  - RGB_VALID ← PIXEL_VALID.
- Blink counter bcnt, range 0..BLINK_FRAMES-1:
  - On each un-paused FRAME_TICK: if bcnt==BLINK_FRAMES-1, then bcnt←0 and blink_phase toggles; else bcnt+1.
- Rainbow counter rcnt, range 0..RAINBOW_FRAMES-1:
  - On each un-paused FRAME_TICK: if rcnt==RAINBOW_FRAMES-1, then rcnt←0 and the LFSR steps; else rcnt+1.
- LFSR: 16-bit Galois, next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0). It never reaches zero from a non-zero seed.
- PAUSE=1 with FRAME_TICK=1: the tick is dropped (pause wins). The tick is not remembered after PAUSE falls.
- PIXEL_VALID and COLOR are never gated by PAUSE. Pixels keep rendering with frozen animation state.

## Timing
- Reset values (asynchronous on RST rising, held while RST=1):
  - RGB=0, RGB_VALID=0
  - bcnt=0, blink_phase=0, rcnt=0, lfsr=LFSR_SEED
- Latency: pixel presented at cycle n appears on RGB/RGB_VALID after edge n+1. Throughput is one pixel per cycle with no stalls.
- Animation state updates at the clock edge closing the FRAME_TICK cycle:
  - a pixel presented in the tick cycle uses the old state;
  - a pixel presented in the following cycle uses the new state.
- Reset mid-frame: output drops to 0/invalid immediately. The first valid pixel after RST deasserts uses reset animation state.
- Back-to-back FRAME_TICK on consecutive cycles: each pulse counts as a separate frame.
- BLINK_FRAMES=1 or RAINBOW_FRAMES=1: the toggle or step happens on every un-paused tick.

## Test plan
- Reset, then PIXEL_VALID=1 with COLOR cycling STRONG, OKAY, WEAK, INVINCIBLE:
  - one cycle later RGB = `BLACK_RGB`, `DARK_GREY_RGB`, `LIGHT_GREY_RGB`, 12'hCE1;
  - RGB_VALID=1 throughout.
- PIXEL_VALID=0 with any COLOR → next cycle RGB=0, RGB_VALID=0. An undefined code (if STATE_W allows) → `BLACK_RGB`.
- RAINBOW_FRAMES=4, COLOR=INVINCIBLE held:
  - after 3 ticks RGB still 12'hCE1;
  - after the 4th tick, the pixel in the next cycle → 12'h270 (lfsr 16'hE270).
- BLINK_FRAMES=8, COLOR=WEAK:
  - ticks 1–7 → `LIGHT_GREY_RGB`;
  - tick 8 → 12'hFFF;
  - tick 16 → `LIGHT_GREY_RGB`.
- PAUSE=1 across 10 FRAME_TICKs, including one in the same cycle PAUSE rises → bcnt, rcnt, lfsr and output colours unchanged. After PAUSE falls, counting resumes from the frozen values.
- Assert RST mid-stream after the LFSR has stepped and blink_phase=1:
  - RGB and RGB_VALID go to 0 asynchronously, without waiting for a clock edge;
  - after release, INVINCIBLE → 12'hCE1 and WEAK → `LIGHT_GREY_RGB`.
